// File: rtl/systolic_output_deskew_if.sv
// ---------------------------------------------------------------------------
// systolic_output_deskew_if
// Bundles the staggered result bus from the systolic array, the aligned-row
// valid/ready output and the status flags of systolic_output_deskew.
//   in_valid[N]      : per-column qualifier of the staggered result bus
//   in_data[N*DW]    : column j at [j*DATA_W +: DATA_W]
//   out_valid/ready  : aligned-row handshake toward the consumer
//   out_data[N*DW]   : aligned head row, same packing as in_data
//   array_stall      : back-pressure toward the array's launch control
//   skew_err         : sticky, a misaligned row was seen
//   overflow         : sticky, an aligned row found the buffer full
// Modports: master = array/consumer side, slave = deskew block.
// ---------------------------------------------------------------------------
interface systolic_output_deskew_if #(
    parameter int N      = 4,
    parameter int DATA_W = 16
);
    logic [N-1:0]        in_valid;
    logic [N*DATA_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [N*DATA_W-1:0] out_data;
    logic                array_stall;
    logic                skew_err;
    logic                overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, array_stall, skew_err, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, array_stall, skew_err, overflow
    );
endinterface

// File: rtl/systolic_output_deskew.sv
// ---------------------------------------------------------------------------
// systolic_output_deskew
// Realigns column-staggered result rows from a systolic array (column j
// lags column 0 by j cycles) into parallel rows, buffers them in a small
// circular FIFO and presents them on a valid/ready handshake. array_stall
// reserves buffer space for every row already launched into the delay lines.
//
// Ports:
//   clk      : single clock, rising edge
//   n_rst    : asynchronous active-low reset
//   clear    : synchronous flush of delay lines, FIFO and sticky flags
//   bus      : systolic_output_deskew_if.slave (data in, rows out, flags)
//   rows_out : 16-bit wrapping pop counter, only with DESKEW_ROW_COUNT_EN
//
// Build option: define DESKEW_ROW_COUNT_EN to add the rows_out counter.
// All outputs are registered.
// ---------------------------------------------------------------------------
module systolic_output_deskew #(
    parameter int N          = 4,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    systolic_output_deskew_if.slave bus
`ifdef DESKEW_ROW_COUNT_EN
    ,
    output logic [15:0] rows_out
`endif
);
    localparam int ROW_W = N * DATA_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    logic [N-1:0]     aligned_vld_s;
    logic [ROW_W-1:0] aligned_row_s;
    logic [N-2:0]     col0_vld_d_s;

    // Per-column delay lines: column j is held N-1-j cycles so all columns
    // of a row line up with the last column.
    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int DEPTH = N - 1 - j;
        if (DEPTH == 0) begin : g_pass
            assign aligned_vld_s[j]                    = bus.in_valid[j];
            assign aligned_row_s[j*DATA_W +: DATA_W] = bus.in_data[j*DATA_W +: DATA_W];
        end else begin : g_delay
            logic [DEPTH-1:0]  vld_q;
            logic [DEPTH-1:0]  vld_d;
            logic [DATA_W-1:0] dat_q [DEPTH];
            logic [DATA_W-1:0] dat_d [DEPTH];

            // Shift valid/data one stage; clear kills only the valids.
            always_comb begin
                vld_d    = vld_q;
                dat_d    = dat_q;
                dat_d[0] = bus.in_data[j*DATA_W +: DATA_W];
                for (int k = 1; k < DEPTH; k++) begin
                    dat_d[k] = dat_q[k-1];
                end
                if (clear) begin
                    vld_d = {DEPTH{1'b0}};
                end else begin
                    vld_d[0] = bus.in_valid[j];
                    for (int k = 1; k < DEPTH; k++) begin
                        vld_d[k] = vld_q[k-1];
                    end
                end
            end

            // Delay-line storage.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    vld_q <= {DEPTH{1'b0}};
                    for (int k = 0; k < DEPTH; k++) begin
                        dat_q[k] <= {DATA_W{1'b0}};
                    end
                end else begin
                    vld_q <= vld_d;
                    dat_q <= dat_d;
                end
            end

            assign aligned_vld_s[j]                    = vld_q[DEPTH-1];
            assign aligned_row_s[j*DATA_W +: DATA_W] = dat_q[DEPTH-1];

            // Column 0's valids mark every launched row still in flight.
            if (j == 0) begin : g_col0
                assign col0_vld_d_s = vld_d;
            end
        end
    end

    logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
    logic [ROW_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [ROW_W-1:0] out_data_q, out_data_d;
    logic             stall_q, stall_d;
    logic             skew_q, skew_d;
    logic             ovf_q, ovf_d;
    logic             all_ones_s, any_s, full_s, push_s, pop_s;
    logic [OCC_W-1:0] occ_s;

    // FIFO control, sticky flags and stall reservation.
    always_comb begin
        all_ones_s  = &aligned_vld_s;
        any_s       = |aligned_vld_s;
        full_s      = (count_q == CNT_W'(FIFO_DEPTH));
        pop_s       = !clear && out_valid_q && bus.out_ready;
        // A full FIFO can still accept when the head leaves this cycle.
        push_s      = !clear && all_ones_s && (!full_s || pop_s);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        skew_d      = skew_q;
        ovf_d       = ovf_q;
        if (clear) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            skew_d   = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            skew_d = skew_q | (any_s && !all_ones_s);
            ovf_d  = ovf_q | (all_ones_s && full_s && !pop_s);
        end
        out_valid_d = (count_d != {CNT_W{1'b0}});
        occ_s       = OCC_W'(count_d);
        for (int k = 0; k < N - 1; k++) begin
            occ_s = occ_s + OCC_W'(col0_vld_d_s[k]);
        end
        stall_d = (occ_s >= OCC_W'(FIFO_DEPTH));
    end

    // Buffer write and next-cycle head row (includes a row pushed into an
    // empty FIFO, since then the write pointer equals the read pointer).
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = aligned_row_s;
        end else begin
            mem_d = mem_q;
        end
        if (clear) begin
            out_data_d = {ROW_W{1'b0}};
        end else begin
            out_data_d = mem_d[rd_ptr_d];
        end
    end

    // FIFO state and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {ROW_W{1'b0}};
            end
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {ROW_W{1'b0}};
            stall_q     <= 1'b0;
            skew_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            stall_q     <= stall_d;
            skew_q      <= skew_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.array_stall = stall_q;
    assign bus.skew_err    = skew_q;
    assign bus.overflow    = ovf_q;

`ifdef DESKEW_ROW_COUNT_EN
    logic [15:0] rows_out_q, rows_out_d;

    // Wrapping count of rows handed downstream.
    always_comb begin
        if (clear) begin
            rows_out_d = 16'h0000;
        end else if (pop_s) begin
            rows_out_d = rows_out_q + 16'h0001;
        end else begin
            rows_out_d = rows_out_q;
        end
    end

    // Pop counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rows_out_q <= 16'h0000;
        end else begin
            rows_out_q <= rows_out_d;
        end
    end

    assign rows_out = rows_out_q;
`endif

endmodule

// File: tb/tb_systolic_output_deskew.sv
// ---------------------------------------------------------------------------
// tb_systolic_output_deskew
// Directed bench for systolic_output_deskew (N=4, DATA_W=16, FIFO_DEPTH=8).
// Rows are launched staggered: a row with base b puts b+j on column j, j
// cycles after launch. Expected rows are {b+3, b+2, b+1, b}.
// Define DESKEW_ROW_COUNT_EN to also exercise rows_out.
// ---------------------------------------------------------------------------
module tb_systolic_output_deskew;
    localparam int N  = 4;
    localparam int DW = 16;

    logic clk;
    logic n_rst;
    logic clear;
`ifdef DESKEW_ROW_COUNT_EN
    logic [15:0] rows_out;
`endif

    systolic_output_deskew_if #(.N(N), .DATA_W(DW)) bus ();

    systolic_output_deskew #(.N(N), .DATA_W(DW), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .bus   (bus)
`ifdef DESKEW_ROW_COUNT_EN
        ,
        .rows_out (rows_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        hv [N];
    logic [15:0] hb [N];
    logic [3:0]  hm [N];

    function automatic logic [63:0] row(input logic [15:0] b);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then drive this cycle's staggered columns.
    task automatic cyc(input bit launch, input logic [15:0] base, input logic [3:0] mask,
                       input bit rdy, input bit clr);
        @(posedge clk);
        #1;
        for (int j = N - 1; j > 0; j--) begin
            hv[j] = hv[j-1];
            hb[j] = hb[j-1];
            hm[j] = hm[j-1];
        end
        hv[0] = launch;
        hb[0] = base;
        hm[0] = mask;
        for (int j = 0; j < N; j++) begin
            bus.in_valid[j] = hv[j] & hm[j][j];
            bus.in_data[j*DW +: DW] = (hv[j] & hm[j][j]) ? hb[j] + 16'(j) : 16'h0000;
        end
        bus.out_ready = rdy;
        clear = clr;
    endtask

    initial begin
        int idx;
        n_rst = 1'b0;
        clear = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int j = 0; j < N; j++) begin
            hv[j] = 1'b0;
            hb[j] = 16'h0000;
            hm[j] = 4'h0;
        end
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_stall", 64'(bus.array_stall), 64'd0);
        chk("rst_skew", 64'(bus.skew_err), 64'd0);
        chk("rst_ovf", 64'(bus.overflow), 64'd0);
        #20;
        n_rst = 1'b1;

        // Single row: launch cycle 0, output in cycle 4 only.
        for (int k = 0; k < 8; k++) begin
            cyc(k == 0, 16'h0010, 4'hF, 1'b1, 1'b0);
            chk("lat_valid", 64'(bus.out_valid), 64'(k == 4));
            if (k == 4) chk("lat_data", bus.out_data, 64'h0013_0012_0011_0010);
        end

        // 20 back-to-back rows, consumer always ready.
        idx = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(k < 20, 16'h0100 + 16'(k * 8), 4'hF, 1'b1, 1'b0);
            chk("stream_valid", 64'(bus.out_valid), 64'(k >= 4 && k < 24));
            if (bus.out_valid) begin
                chk("stream_data", bus.out_data, row(16'h0100 + 16'(idx * 8)));
                idx++;
            end
            chk("stream_stall", 64'(bus.array_stall), 64'd0);
            chk("stream_flags", 64'({bus.skew_err, bus.overflow}), 64'd0);
        end
        chk("stream_count", 64'(idx), 64'd20);

        // Fill with consumer stalled: stall must rise right after launch 8.
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 16'h0200 + 16'(k * 8), 4'hF, 1'b0, 1'b0);
            chk("fill_stall_low", 64'(bus.array_stall), 64'd0);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 16'h0000, 4'hF, 1'b0, 1'b0);
            chk("fill_stall_high", 64'(bus.array_stall), 64'd1);
            chk("fill_ovf", 64'(bus.overflow), 64'd0);
        end
        idx = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 16'h0000, 4'hF, 1'b1, 1'b0);
            if (bus.out_valid) begin
                chk("drain_data", bus.out_data, row(16'h0200 + 16'(idx * 8)));
                idx++;
            end
        end
        chk("drain_count", 64'(idx), 64'd8);
        chk("drain_stall", 64'(bus.array_stall), 64'd0);

        // Ninth row ignoring stall while full.
        for (int k = 0; k < 13; k++) begin
            cyc(k < 9, 16'h0300 + 16'(k * 8), 4'hF, 1'b0, 1'b0);
            if (k == 11) chk("ovf_before", 64'(bus.overflow), 64'd0);
            if (k == 12) begin
                chk("ovf_set", 64'(bus.overflow), 64'd1);
                chk("ovf_head", bus.out_data, row(16'h0300));
                chk("ovf_valid", 64'(bus.out_valid), 64'd1);
            end
        end
        idx = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 16'h0000, 4'hF, 1'b1, 1'b0);
            if (bus.out_valid) begin
                chk("ovf_drain_data", bus.out_data, row(16'h0300 + 16'(idx * 8)));
                idx++;
            end
        end
        chk("ovf_drain_count", 64'(idx), 64'd8);
        chk("ovf_sticky", 64'(bus.overflow), 64'd1);
        for (int k = 0; k < 7; k++) begin
            cyc(k < 2, 16'h0400 + 16'(k * 8), 4'hF, 1'b0, 1'b0);
        end
        chk("pre_clear_valid", 64'(bus.out_valid), 64'd1);
        cyc(1'b0, 16'h0000, 4'hF, 1'b0, 1'b1);
        cyc(1'b0, 16'h0000, 4'hF, 1'b0, 1'b0);
        chk("clear_ovf", 64'(bus.overflow), 64'd0);
        chk("clear_valid", 64'(bus.out_valid), 64'd0);
        chk("clear_stall", 64'(bus.array_stall), 64'd0);

        // Row missing column 3.
        for (int k = 0; k < 8; k++) begin
            cyc(k == 0, 16'h0500, 4'b0111, 1'b1, 1'b0);
            if (k == 3) chk("skew_before", 64'(bus.skew_err), 64'd0);
            if (k == 4) chk("skew_set", 64'(bus.skew_err), 64'd1);
            chk("skew_no_push", 64'(bus.out_valid), 64'd0);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(k == 0, 16'h0600, 4'hF, 1'b1, 1'b0);
            chk("skew_good_valid", 64'(bus.out_valid), 64'(k == 4));
            if (k == 4) chk("skew_good_data", bus.out_data, row(16'h0600));
        end
        chk("skew_sticky", 64'(bus.skew_err), 64'd1);

        // Asynchronous reset with three rows buffered.
        for (int k = 0; k < 7; k++) begin
            cyc(k < 3, 16'h0700 + 16'(k * 8), 4'hF, 1'b0, 1'b0);
        end
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("pre_rst_data", bus.out_data, row(16'h0700));
        #3;
        n_rst = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_data", bus.out_data, 64'd0);
        chk("arst_stall", 64'(bus.array_stall), 64'd0);
        chk("arst_skew", 64'(bus.skew_err), 64'd0);
        chk("arst_ovf", 64'(bus.overflow), 64'd0);
        #10;
        n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 16'h0000, 4'hF, 1'b1, 1'b0);
            chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
        end

`ifdef DESKEW_ROW_COUNT_EN
        cyc(1'b0, 16'h0000, 4'hF, 1'b1, 1'b1);
        cyc(1'b0, 16'h0000, 4'hF, 1'b1, 1'b0);
        chk("rows_out_zero", 64'(rows_out), 64'd0);
        for (int k = 0; k < 65537; k++) begin
            cyc(1'b1, 16'(k), 4'hF, 1'b1, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 16'h0000, 4'hF, 1'b1, 1'b0);
        end
        chk("rows_out_wrap", 64'(rows_out), 64'd1);
        chk("rows_out_idle", 64'(bus.out_valid), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
